// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4 slave memory for L2 line fills and writebacks.
// Single-port synchronous SRAM, one INCR burst at a time, 32-bit beats.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   s_aw*                write address channel (addr, len, valid/ready)
//   s_w*                 write data channel (data, last, valid/ready)
//   s_b*                 write response channel (always OKAY)
//   s_ar*                read address channel (addr, len, valid/ready)
//   s_r*                 read data channel (data, last, valid/ready)
//
// Optional build macro: AXI_SRAM_LATENCY_EN
//   Adds a WAIT_LAT state holding off the first beat for ACCESS_LATENCY
//   cycles after every AW/AR handshake.

module axi_sram_responder #(
    parameter int MEM_WORDS      = 65536,
    parameter int ADDR_WIDTH     = 32,
    parameter int ACCESS_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WBURST = 3'd1;
    localparam logic [2:0] ST_WRESP  = 3'd2;
    localparam logic [2:0] ST_RBURST = 3'd3;
`ifdef AXI_SRAM_LATENCY_EN
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam int LW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_INIT =
        LW'((ACCESS_LATENCY > 0) ? ACCESS_LATENCY - 1 : 0);
    localparam bit LAT_ON = (ACCESS_LATENCY != 0);
`endif

    // FSM and burst bookkeeping
    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic [31:0]   rdata_q;

`ifdef AXI_SRAM_LATENCY_EN
    logic [LW-1:0] lat_q, lat_d;
    logic          rd_q, rd_d;
`else
    logic          unused_lat;
    assign unused_lat = (ACCESS_LATENCY != 0);
`endif

    // Single SRAM port, shared between write beats and read fetches
    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic          rd_issue;

    logic [AW-1:0] aw_word;
    logic [AW-1:0] ar_word;

    // Byte offset and bits above the array size are don't-care
    assign aw_word = s_awaddr[AW+1:2];
    assign ar_word = s_araddr[AW+1:2];

    logic unused_addr;
    assign unused_addr = ^{s_awaddr, s_araddr};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_q;
        rd_issue  = 1'b0;
        s_awready = 1'b0;
        s_arready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
`ifdef AXI_SRAM_LATENCY_EN
        lat_d     = lat_q;
        rd_d      = rd_q;
`endif

        if (!reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Write wins a tie so a writeback lands before its fill
                    s_awready = 1'b1;
                    s_arready = !s_awvalid;
                    if (s_awvalid) begin
                        addr_d  = aw_word;
                        cnt_d   = s_awlen;
                        state_d = ST_WBURST;
`ifdef AXI_SRAM_LATENCY_EN
                        if (LAT_ON) begin
                            state_d = ST_WAIT;
                            lat_d   = LAT_INIT;
                            rd_d    = 1'b0;
                        end
`endif
                    end else if (s_arvalid) begin
                        addr_d   = ar_word;
                        cnt_d    = s_arlen;
                        rd_issue = 1'b1;
`ifdef AXI_SRAM_LATENCY_EN
                        if (LAT_ON) begin
                            rd_issue = 1'b0;
                            state_d  = ST_WAIT;
                            lat_d    = LAT_INIT;
                            rd_d     = 1'b1;
                        end
`endif
                    end
                end

                ST_WBURST: begin
                    s_wready = 1'b1;
                    if (s_wvalid) begin
                        mem_we = 1'b1;
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 8'd1;
                        // Beat count, not wlast, ends the burst
                        if (cnt_q == 8'd0) begin
                            state_d = ST_WRESP;
                        end
                    end
                end

                ST_WRESP: begin
                    s_bvalid = 1'b1;
                    if (s_bready) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_RBURST: begin
                    // rvalid_q is always set here; the held beat
                    // stays in rdata_q until it is taken
                    if (s_rready) begin
                        if (cnt_q == 8'd0) begin
                            rvalid_d = 1'b0;
                            rlast_d  = 1'b0;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d    = cnt_q - 8'd1;
                            rd_issue = 1'b1;
                        end
                    end
                end

`ifdef AXI_SRAM_LATENCY_EN
                ST_WAIT: begin
                    if (lat_q == '0) begin
                        if (rd_q) begin
                            rd_issue = 1'b1;
                        end else begin
                            state_d = ST_WBURST;
                        end
                    end else begin
                        lat_d = lat_q - 1'b1;
                    end
                end
`endif

                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Fetch the word at addr_d into the output register and
            // advance so the next beat can follow one cycle later
            if (rd_issue) begin
                mem_re   = 1'b1;
                mem_addr = addr_d;
                addr_d   = addr_d + 1'b1;
                rvalid_d = 1'b1;
                rlast_d  = (cnt_d == 8'd0);
                state_d  = ST_RBURST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
`ifdef AXI_SRAM_LATENCY_EN
            lat_q    <= '0;
            rd_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            if (mem_re) begin
                rdata_q <= mem[mem_addr];
            end
`ifdef AXI_SRAM_LATENCY_EN
            lat_q    <= lat_d;
            rd_q     <= rd_d;
`endif
        end
    end

    // Array itself is never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= s_wdata;
        end
    end

    assign s_rdata  = rdata_q;
    assign s_rvalid = rvalid_q;
    assign s_rlast  = rlast_q;

    // wlast is informational only; flag masters that disagree with awlen
    always @(posedge clk) begin
        if (!reset && state_q == ST_WBURST && s_wvalid) begin
            assert (s_wlast == (cnt_q == 8'd0))
            else $error("axi_sram_responder: wlast disagrees with awlen");
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: directed checks of the AXI SRAM responder.
// Uses a 1024-word array so addresses alias modulo 4 KiB.

module tb_axi_sram_responder;

    localparam int MW = 1024;
`ifdef AXI_SRAM_LATENCY_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_awaddr = '0;
    logic [7:0]  s_awlen = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic        s_wlast = 1'b0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    logic [31:0] mem_m [MW];

    axi_sram_responder #(
        .MEM_WORDS(MW),
        .ADDR_WIDTH(32),
        .ACCESS_LATENCY(8)
    ) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a, input int i);
        return ((a >> 2) + i) % MW;
    endfunction

    task automatic do_write(input logic [31:0] a, input int len,
                            input logic [31:0] dbase, output int lat);
        int h;
        int w;
        lat = -1;
        @(negedge clk);
        s_awaddr = a; s_awlen = 8'(len); s_awvalid = 1'b1;
        #1;
        w = 0;
        while (!s_awready && w < 50) begin @(negedge clk); #1; w++; end
        chk("aw_accept", s_awready, 1);
        h = cyc + 1;
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            s_wdata = dbase + 32'(i);
            s_wlast = (i == len);
            s_wvalid = 1'b1;
            #1;
            w = 0;
            while (!s_wready && w < 50) begin @(negedge clk); #1; w++; end
            mem_m[widx(a, i)] = dbase + 32'(i);
            @(negedge clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        #1;
        w = 0;
        while (!s_bvalid && w < 50) begin @(negedge clk); #1; w++; end
        if (s_bvalid) lat = cyc + 1 - h;
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    // pat bit k drives rready in the k-th cycle once data is valid
    task automatic do_read(input logic [31:0] a, input int len,
                           input logic [31:0] pat, output int lat);
        int h, w, beat, k;
        logic stall;
        logic [31:0] pd;
        logic pl;
        lat = -1;
        @(negedge clk);
        s_araddr = a; s_arlen = 8'(len); s_arvalid = 1'b1;
        #1;
        w = 0;
        while (!s_arready && w < 50) begin @(negedge clk); #1; w++; end
        chk("ar_accept", s_arready, 1);
        h = cyc + 1;
        @(negedge clk);
        s_arvalid = 1'b0;
        #1;
        w = 0;
        while (!s_rvalid && w < 50) begin @(negedge clk); #1; w++; end
        if (s_rvalid) lat = cyc + 1 - h;
        beat = 0; k = 0; stall = 1'b0; pd = '0; pl = 1'b0;
        while (beat <= len && k < 200) begin
            s_rready = (k < 32) ? pat[k] : 1'b1;
            #1;
            chk("r_valid_held", s_rvalid, 1);
            if (stall) begin
                chk("r_data_stable", s_rdata, pd);
                chk("r_last_stable", s_rlast, pl);
            end
            if (s_rvalid && s_rready) begin
                chk("r_data", s_rdata, mem_m[widx(a, beat)]);
                chk("r_last", s_rlast, (beat == len));
                beat++;
                stall = 1'b0;
            end else begin
                stall = s_rvalid;
                pd = s_rdata; pl = s_rlast;
            end
            @(negedge clk);
            k++;
        end
        s_rready = 1'b0;
        #1;
        chk("r_beats", beat, len + 1);
        chk("r_valid_done", s_rvalid, 0);
    endtask

    initial begin
        int lat;
        int w;
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", s_awready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_wready", s_wready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_rlast", s_rlast, 0);
        chk("rst_rdata", s_rdata, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_awready", s_awready, 1);
        chk("idle_arready", s_arready, 1);

        // Write 0..15 at 0x1000, then read it back
        do_write(32'h1000, 15, 32'h0, lat);
        chk("wr_latency", lat, 17 + LAT);
        do_read(32'h1000, 15, 32'hFFFF_FFFF, lat);
        chk("rd_latency", lat, 1 + LAT);

        // Simultaneous AW/AR: 0x2000 and 0x3000 both alias word 0
        @(negedge clk);
        s_awaddr = 32'h2000; s_awlen = 8'd0; s_awvalid = 1'b1;
        s_araddr = 32'h3000; s_arlen = 8'd0; s_arvalid = 1'b1;
        #1;
        chk("tie_awready", s_awready, 1);
        chk("tie_arready", s_arready, 0);
        @(negedge clk);
        s_awvalid = 1'b0;
        s_wdata = 32'hCAFE_0000; s_wlast = 1'b1; s_wvalid = 1'b1;
        #1;
        w = 0;
        while (!s_wready && w < 50) begin @(negedge clk); #1; w++; end
        chk("tie_arready_w", s_arready, 0);
        @(negedge clk);
        s_wvalid = 1'b0; s_wlast = 1'b0;
        mem_m[0] = 32'hCAFE_0000;
        #1;
        w = 0;
        while (!s_bvalid && w < 50) begin @(negedge clk); #1; w++; end
        chk("tie_bvalid", s_bvalid, 1);
        chk("tie_arready_b", s_arready, 0);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        #1;
        chk("tie_ar_after_b", s_arready, 1);
        @(negedge clk);
        s_arvalid = 1'b0;
        #1;
        w = 0;
        while (!s_rvalid && w < 50) begin @(negedge clk); #1; w++; end
        chk("tie_rvalid", s_rvalid, 1);
        chk("tie_rdata", s_rdata, 32'hCAFE_0000);
        chk("tie_rlast", s_rlast, 1);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        #1;
        chk("tie_rdone", s_rvalid, 0);

        // Backpressure: rready 1,0,0,1 then 1 on words 4..7
        do_read(32'h1010, 3, 32'hFFFF_FFF9, lat);

        // Wrap: 0xFF8 len 3 -> words 1022, 1023, 0, 1
        do_write(32'h0FF8, 3, 32'h100, lat);
        chk("wrap_wr_latency", lat, 5 + LAT);
        do_read(32'h0FF8, 3, 32'hFFFF_FFFF, lat);
        do_read(32'h0000, 1, 32'hFFFF_FFFF, lat);

        // Reset during beat 2 of a len-7 read
        @(negedge clk);
        s_araddr = 32'h1000; s_arlen = 8'd7; s_arvalid = 1'b1;
        #1;
        w = 0;
        while (!s_arready && w < 50) begin @(negedge clk); #1; w++; end
        @(negedge clk);
        s_arvalid = 1'b0;
        s_rready = 1'b1;
        #1;
        w = 0;
        while (!s_rvalid && w < 50) begin @(negedge clk); #1; w++; end
        chk("rst_b1_data", s_rdata, 32'h102);
        @(negedge clk);
        #1;
        chk("rst_b2_valid", s_rvalid, 1);
        chk("rst_b2_data", s_rdata, 32'h103);
        reset = 1'b1;
        s_rready = 1'b0;
        #1;
        chk("rst_mid_arready", s_arready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_rvalid", s_rvalid, 0);
        chk("rst_mid_rlast", s_rlast, 0);
        chk("rst_mid_arready1", s_arready, 1);
        do_read(32'h1020, 1, 32'hFFFF_FFFF, lat);
        chk("post_rst_latency", lat, 1 + LAT);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI4 slave memory that services the L2 cache's external-bus master: line fills (AR/R bursts) and dirty writebacks (AW/W/B bursts).
- Backed by a single-port synchronous SRAM array.
- Used as on-chip system memory in FPGA builds and as the memory model in simulation.
- Handles one transaction at a time. Bursts are INCR only, one 32-bit word per beat.

Parameters:
MEM_WORDS, 65536, number of 32-bit words in the array; must be a power of two.
ADDR_WIDTH, 32, AXI address width.
ACCESS_LATENCY, 8, extra cycles inserted before the first beat; used only with AXI_SRAM_LATENCY_EN.

Ports:
clk  in  1  clock; the block uses one clock.
reset  in  1  synchronous, active-high reset.
s_awaddr  in  ADDR_WIDTH  write burst start byte address
s_awlen  in  8  write beats minus 1
s_awvalid  in  1  write address valid
s_awready  out  1  write address accepted
s_wdata  in  32  write beat data
s_wlast  in  1  final write beat
s_wvalid  in  1  write data valid
s_wready  out  1  write data accepted
s_bvalid  out  1  write response valid (response is always OKAY)
s_bready  in  1  write response accepted
s_araddr  in  ADDR_WIDTH  read burst start byte address
s_arlen  in  8  read beats minus 1
s_arvalid  in  1  read address valid
s_arready  out  1  read address accepted
s_rdata  out  32  read beat data
s_rlast  out  1  final read beat
s_rvalid  out  1  read data valid
s_rready  in  1  read data accepted

Behaviour:
- Reset:
  - State goes to IDLE.
  - s_awready, s_wready, s_bvalid, s_arready, s_rvalid and s_rlast are all 0. s_rdata is 0.
  - Memory contents are not cleared.
  - Reset asserted mid-burst abandons the burst. No response is issued. Words already written stay written.
- State machine: IDLE, WRITE_BURST, WRITE_RESP, READ_BURST, plus WAIT_LAT when the feature is on.
- IDLE:
  - s_awready = 1 and s_arready = 1 combinationally, unless both s_awvalid and s_arvalid are 1. In that case only s_awready = 1: write wins, so a writeback always completes before the fill that follows it.
  - On AW handshake: latch word address = awaddr[log2(MEM_WORDS)+1:2], latch count = awlen, go to WRITE_BURST.
  - On AR handshake: latch the address and arlen the same way, go to READ_BURST.
- WRITE_BURST:
  - s_wready = 1.
  - Each W handshake writes s_wdata to mem[addr], increments addr, and decrements count.
  - Leave after the beat where count == 0, going to WRITE_RESP.
  - s_wlast is not used to end the burst. A mismatch between s_wlast and count == 0 is only flagged by a simulation assertion.
- WRITE_RESP: s_bvalid = 1 until s_bready, then return to IDLE. Write latency from AW handshake to s_bvalid is len+2 cycles when W is continuously valid.
- READ_BURST:
  - The SRAM read is registered. The first s_rvalid is asserted the cycle after the AR handshake.
  - s_rlast = 1 when count == 0.
  - On an R handshake, the next beat is available the following cycle (prefetch the next address on handshake). Back-to-back beats give 1 beat per cycle.
  - While s_rready = 0, s_rdata and s_rlast hold stable.
  - After the last handshake: s_rvalid = 0, return to IDLE.
- Address arithmetic: the word address wraps modulo MEM_WORDS. A burst that crosses the top of the array continues at word 0. Byte-offset bits [1:0] are ignored.
- No outstanding-transaction queue. A new AW/AR is accepted only in IDLE, so the earliest is the cycle after the previous burst completes.

Optional Feature:
- Macro: AXI_SRAM_LATENCY_EN.
- Defined:
  - After any AW or AR handshake, the FSM enters WAIT_LAT for ACCESS_LATENCY cycles (down-counter) with s_wready, s_rvalid and s_bvalid held at 0.
  - It then proceeds to WRITE_BURST or READ_BURST.
  - ACCESS_LATENCY = 0 behaves exactly as the undefined case.
- Undefined: WAIT_LAT and its counter are not compiled in. Timing is as described in Behaviour.

Test Plan:
- Write then read, same address:
  - AW addr 0x1000, len 15, W data 0..15 streamed -> s_bvalid 17 cycles after the AW handshake.
  - AR addr 0x1000, len 15, rready held 1 -> 16 consecutive beats with data 0..15, s_rlast only on beat 16.
- Simultaneous AW and AR in IDLE (AW 0x2000, AR 0x3000) -> AW accepted first, s_arready = 0 that cycle; AR accepted in the first IDLE cycle after the B handshake.
- Read backpressure: rready toggled 1,0,0,1 during a len-3 burst -> s_rdata/s_rlast stable while stalled; exactly 4 beats, in order.
- Wrap: MEM_WORDS = 1024, AW addr 0xFF8, len 3 -> words 1022, 1023, 0, 1 written; read back matches.
- Reset asserted on beat 2 of a len-7 read -> next cycle s_rvalid = 0, s_arready = 1 (IDLE); a subsequent read returns correct data.
- With AXI_SRAM_LATENCY_EN, ACCESS_LATENCY = 8: AR handshake -> first s_rvalid exactly 9 cycles later.
